// File: rtl/input_scheduler.sv
// input_scheduler: turns held button levels into single-cycle command pulses
// for game_control. Left/right use DAS/ARR auto-repeat through one shared
// direction register. Down repeats while held. Rotate, drop and hold fire
// only on the press edge. Requested commands wait in a pending set, and a
// fixed-priority issuer releases them one at a time whenever game_control
// reports that it is ready.
module input_scheduler #(
    parameter int DAS_FRAMES  = 10,
    parameter int ARR_FRAMES  = 2,
    parameter int SOFT_FRAMES = 2,
    parameter int COOL_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_game,
    input  logic       game_over,
    input  logic       cmd_ready,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_rotate,
    input  logic       btn_drop,
    input  logic       btn_hold,
    output logic       key_left,
    output logic       key_right,
    output logic       key_down,
    output logic       key_rotate,
    output logic       key_drop,
    output logic       key_hold,
    output logic       key_drop_held,
    output logic [7:0] coalesced
);

    // Bit positions in the pending set. A higher index means higher priority.
    localparam int B_DOWN   = 0;
    localparam int B_RIGHT  = 1;
    localparam int B_LEFT   = 2;
    localparam int B_ROTATE = 3;
    localparam int B_HOLD   = 4;
    localparam int B_DROP   = 5;

    localparam logic [5:0] DROP_MASK = 6'b10_0000;
    localparam logic [5:0] EDGE_ONLY = 6'b11_1000;
    localparam logic [7:0] DAS_LIM   = 8'(DAS_FRAMES);
    localparam logic [7:0] ARR_LIM   = 8'(ARR_FRAMES);
    localparam logic [7:0] SOFT_LIM  = 8'(SOFT_FRAMES);
    localparam logic [3:0] COOL_LAST = 4'(COOL_CYCLES - 1);

    typedef enum logic [1:0] {H_IDLE, H_DAS, H_ARR} h_state_t;
    typedef enum logic [1:0] {S_WAIT, S_ISSUE, S_COOL} i_state_t;

    // Returns the highest set bit as a one-hot vector, or zero if none is set.
    function automatic logic [5:0] pick_highest(input logic [5:0] v);
        pick_highest = '0;
        for (int i = 0; i < 6; i++)
            if (v[i]) pick_highest = 6'b1 << i;
    endfunction

    logic [5:0] btn_vec, prev_q, press;
    logic [5:0] pending_q, pending_d, set_raw, set_ev, clr, keep_mask, merged;
    logic [5:0] key_q, key_d, eligible;
    logic [7:0] coal_q, coal_d, soft_cnt_q, soft_cnt_d, h_cnt_q, h_cnt_d, h_lim;
    logic [8:0] coal_sum;
    logic [3:0] cool_q, cool_d;
    logic       soft_set, dir_q, dir_d, dir_held, opp_held, opp_press;
    logic [5:0] h_set;
    h_state_t   h_state_q, h_state_d;
    i_state_t   i_state_q, i_state_d;

    assign btn_vec = {btn_drop, btn_hold, btn_rotate, btn_left, btn_right, btn_down};
    assign press   = btn_vec & ~prev_q;

    // dir_q = 1 means left is the active direction.
    assign dir_held  = dir_q ? btn_left : btn_right;
    assign opp_held  = dir_q ? btn_right : btn_left;
    assign opp_press = dir_q ? press[B_RIGHT] : press[B_LEFT];
    assign h_lim     = (h_state_q == H_DAS) ? DAS_LIM : ARR_LIM;

    // Horizontal DAS/ARR next state; game_over parks it in H_IDLE.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave it unassigned and infer a latch.
        h_state_d = h_state_q;
        dir_d     = dir_q;
        h_cnt_d   = h_cnt_q;
        h_set     = '0;
        unique case (h_state_q)
            H_IDLE: begin
                if (press[B_LEFT]) begin
                    dir_d         = 1'b1;
                    h_set[B_LEFT] = 1'b1;
                    h_cnt_d       = '0;
                    h_state_d     = H_DAS;
                end else if (press[B_RIGHT]) begin
                    dir_d          = 1'b0;
                    h_set[B_RIGHT] = 1'b1;
                    h_cnt_d        = '0;
                    h_state_d      = H_DAS;
                end
            end
            H_DAS, H_ARR: begin
                if (opp_press || (!dir_held && opp_held)) begin
                    dir_d                            = ~dir_q;
                    h_set[dir_q ? B_RIGHT : B_LEFT] = 1'b1;
                    h_cnt_d                          = '0;
                    h_state_d                        = H_DAS;
                end else if (!dir_held) begin
                    h_cnt_d   = '0;
                    h_state_d = H_IDLE;
                end else if (tick_game) begin
                    if (h_cnt_q + 8'd1 == h_lim) begin
                        h_set[dir_q ? B_LEFT : B_RIGHT] = 1'b1;
                        h_cnt_d                          = '0;
                        h_state_d                        = H_ARR;
                    end else begin
                        h_cnt_d = h_cnt_q + 8'd1;
                    end
                end
            end
            default: h_state_d = H_IDLE;
        endcase
        if (game_over) begin
            h_state_d = H_IDLE;
            h_cnt_d   = '0;
            h_set     = '0;
        end
    end

    // Soft-drop repeat: the press fires at once, then one repeat every SOFT_FRAMES ticks while held.
    always_comb begin
        soft_cnt_d = soft_cnt_q;
        soft_set   = 1'b0;
        if (press[B_DOWN]) begin
            soft_set   = 1'b1;
            soft_cnt_d = '0;
        end else if (!btn_down) begin
            soft_cnt_d = '0;
        end else if (tick_game) begin
            if (soft_cnt_q + 8'd1 == SOFT_LIM) begin
                soft_set   = 1'b1;
                soft_cnt_d = '0;
            end else begin
                soft_cnt_d = soft_cnt_q + 8'd1;
            end
        end
    end

    // Pending set update: a set beats a same-cycle clear, and a repeat set on a still-pending bit is counted as merged.
    always_comb begin
        set_raw   = (press & EDGE_ONLY) | h_set | {5'b0, soft_set};
        set_ev    = game_over ? (set_raw & DROP_MASK) : set_raw;
        clr       = (i_state_q == S_ISSUE) ? key_q : '0;
        keep_mask = game_over ? DROP_MASK : 6'h3F;
        pending_d = (pending_q & ~clr & keep_mask) | set_ev;
        merged    = set_ev & pending_q & ~clr;
        coal_sum  = {1'b0, coal_q} + 9'($countones(merged));
        coal_d    = coal_sum[8] ? 8'hFF : coal_sum[7:0];
    end

    // Issuer next state: wait for ready, pulse one command, then cool down.
    always_comb begin
        i_state_d = i_state_q;
        cool_d    = cool_q;
        key_d     = '0;
        eligible  = game_over ? (pending_q & DROP_MASK) : pending_q;
        unique case (i_state_q)
            S_WAIT: begin
                if (cmd_ready && eligible != '0) begin
                    key_d     = pick_highest(eligible);
                    i_state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cool_d    = '0;
                i_state_d = S_COOL;
            end
            S_COOL: begin
                if (cool_q == COOL_LAST) i_state_d = S_WAIT;
                else                     cool_d    = cool_q + 4'd1;
            end
            default: i_state_d = S_WAIT;
        endcase
    end

    // State registers. Reset drops a pulse that is in flight immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            pending_q  <= '0;
            coal_q     <= '0;
            soft_cnt_q <= '0;
            h_state_q  <= H_IDLE;
            dir_q      <= 1'b0;
            h_cnt_q    <= '0;
            i_state_q  <= S_WAIT;
            cool_q     <= '0;
            key_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from the values held before this edge.
            prev_q     <= btn_vec;
            pending_q  <= pending_d;
            coal_q     <= coal_d;
            soft_cnt_q <= soft_cnt_d;
            h_state_q  <= h_state_d;
            dir_q      <= dir_d;
            h_cnt_q    <= h_cnt_d;
            i_state_q  <= i_state_d;
            cool_q     <= cool_d;
            key_q      <= key_d;
        end
    end

    assign key_down      = key_q[B_DOWN];
    assign key_right     = key_q[B_RIGHT];
    assign key_left      = key_q[B_LEFT];
    assign key_rotate    = key_q[B_ROTATE];
    assign key_hold      = key_q[B_HOLD];
    assign key_drop      = key_q[B_DROP];
    assign key_drop_held = prev_q[B_DROP];
    assign coalesced     = coal_q;

endmodule
